// File: rtl/cpu_reg_pkg.sv
// rtl/cpu_reg_pkg.sv - shared widths, reset constants and load-select priority encoder for cpu_reg_counter
package cpu_reg_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 16;

    localparam logic [CPU_DATA_W-1:0] S_RESET   = 8'hFD;
    localparam logic [CPU_DATA_W-1:0] PCL_RESET = 8'h00;
    localparam logic [CPU_DATA_W-1:0] PCH_RESET = 8'h00;

    typedef enum logic [1:0] {
        CNT_NONE = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Highest set bit wins; callers only use the result when some bit is set.
    function automatic int unsigned prio_encode(input logic [31:0] sel);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (sel[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cpu_reg_bus_port.sv
// rtl/cpu_reg_bus_port.sv - one bus output port: shadow of the last driven value plus output mux
module cpu_reg_bus_port
    import cpu_reg_pkg::*;
#(
    parameter int WIDTH = CPU_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid
);

    logic [WIDTH-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (en) begin
            shadow_q <= value;
        end
    end

    assign bus_out   = en ? value : shadow_q;
    assign bus_valid = en;

endmodule

// File: rtl/cpu_reg_counter.sv
// rtl/cpu_reg_counter.sv - clocked 6502 datapath register with prioritised loads, inc/dec counter and held bus ports; carry chaining under CPU_REG_CARRY_CHAIN_EN
module cpu_reg_counter
    import cpu_reg_pkg::*;
#(
    parameter int                WIDTH       = CPU_DATA_W,
    parameter int                NUM_SRC     = 2,
    parameter int                NUM_BUS     = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       HOLD,
    input  logic [NUM_SRC-1:0]         LOAD_SEL,
    input  logic [NUM_SRC*WIDTH-1:0]   LOAD_DATA,
    input  logic                       INC,
    input  logic                       DEC,
`ifdef CPU_REG_CARRY_CHAIN_EN
    input  logic                       CARRY_IN,
    output logic                       CARRY_OUT,
`endif
    input  logic [NUM_BUS-1:0]         BUS_EN,
    output logic [NUM_BUS*WIDTH-1:0]   BUS_OUT,
    output logic [NUM_BUS-1:0]         BUS_VALID,
    output logic [WIDTH-1:0]           VALUE
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] load_val;
    logic [31:0]      sel_ext;
    int unsigned      sel_idx;
    logic             any_load;
    logic             count_gate;
    cnt_op_e          cnt_op;

`ifdef CPU_REG_CARRY_CHAIN_EN
    assign count_gate = CARRY_IN;
`else
    assign count_gate = 1'b1;
`endif

    assign any_load = |LOAD_SEL;

    always_comb begin
        sel_ext = '0;
        sel_ext[NUM_SRC-1:0] = LOAD_SEL;
        sel_idx  = prio_encode(sel_ext);
        load_val = LOAD_DATA[sel_idx*WIDTH +: WIDTH];
    end

    // INC and DEC together cancel out rather than picking one.
    always_comb begin
        cnt_op = CNT_NONE;
        if (count_gate && INC && !DEC) begin
            cnt_op = CNT_INC;
        end else if (count_gate && DEC && !INC) begin
            cnt_op = CNT_DEC;
        end
    end

    always_comb begin
        reg_d = reg_q;
        if (!HOLD) begin
            if (any_load) begin
                reg_d = load_val;
            end else if (cnt_op == CNT_INC) begin
                reg_d = reg_q + WIDTH'(1);
            end else if (cnt_op == CNT_DEC) begin
                reg_d = reg_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reg_q <= RESET_VALUE;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign VALUE = reg_q;

`ifdef CPU_REG_CARRY_CHAIN_EN
    assign CARRY_OUT = !HOLD && !any_load &&
                       (((cnt_op == CNT_INC) && (&reg_q)) ||
                        ((cnt_op == CNT_DEC) && !(|reg_q)));
`endif

    for (genvar k = 0; k < NUM_BUS; k++) begin : g_bus
        cpu_reg_bus_port #(
            .WIDTH(WIDTH)
        ) u_port (
            .clk      (CLK),
            .rst      (RST),
            .en       (BUS_EN[k]),
            .value    (reg_q),
            .bus_out  (BUS_OUT[k*WIDTH +: WIDTH]),
            .bus_valid(BUS_VALID[k])
        );
    end

endmodule
